// File: rtl/mux8_rr_arbiter_if.sv
// Handshake bundle between the 8-way round-robin arbiter and its requesters/consumer.
// The master modport is the arbiter side. The slave modport is the environment side.
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       out_valid;
    logic       beat_done;
    logic       busy;

    modport master (
        input  req,
        input  out_ready,
        output sel,
        output gnt,
        output out_valid,
        output beat_done,
        output busy
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  gnt,
        input  out_valid,
        input  beat_done,
        input  busy
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 datapath mux.
// A grant is held across a burst and released on request drop or after MAX_BURST accepted beats.
module mux8_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux8_rr_arbiter_if.master bus
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       last_q, last_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic       busy;
    logic       out_valid;
    logic       beat_done;
    logic       found;
    logic [2:0] winner;
    logic [2:0] idx;

    assign busy      = (state_q == GRANT);
    assign out_valid = busy & bus.req[sel_q];
    assign beat_done = out_valid & bus.out_ready;

    // Search starts one past the last granted index, so the previous owner ranks lowest.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        idx    = last_q;
        for (int i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    sel_d      = winner;
                    gnt_d      = 8'b1 << winner;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q] ||
                    ((MAX_BURST != 0) && beat_done && (beat_cnt_q == CNT_LAST))) begin
                    state_d    = IDLE;
                    gnt_d      = 8'h00;
                    last_d     = sel_q;
                    beat_cnt_d = '0;
                end else if (beat_done && (beat_cnt_q != CNT_MAX)) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 3'd0;
            gnt_q      <= 8'h00;
            last_q     <= 3'd7;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.beat_done = beat_done;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: a burst-limited instance and an unlimited-burst instance.
module tb_mux8_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    mux8_rr_arbiter_if ifa ();
    mux8_rr_arbiter_if ifb ();

    mux8_rr_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );

    mux8_rr_arbiter #(.MAX_BURST(0), .CNT_W(8)) dut_u (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        ifa.req       = 8'h00;
        ifa.out_ready = 1'b1;
        ifb.req       = 8'h00;
        ifb.out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // Reset asserted mid-burst with all requests high
        ifa.req = 8'hFF;
        step();
        chk("pre_rst_gnt", ifa.gnt, 8'h01);
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_gnt", ifa.gnt, 8'h00);
        chk("rst_busy", ifa.busy, 1'b0);
        chk("rst_beat_done", ifa.beat_done, 1'b0);
        chk("rst_out_valid", ifa.out_valid, 1'b0);
        ifa.req = 8'h00;
        step();
        rst_n = 1'b1;
        chk("idle_sel", ifa.sel, 3'd0);
        chk("idle_gnt", ifa.gnt, 8'h00);
        chk("idle_out_valid", ifa.out_valid, 1'b0);
        step();
        chk("idle_stay_busy", ifa.busy, 1'b0);
        ifa.req = 8'h01;
        step();
        chk("first_gnt", ifa.gnt, 8'h01);
        chk("first_sel", ifa.sel, 3'd0);
        chk("first_busy", ifa.busy, 1'b1);
        ifa.req = 8'h00;
        step();
        chk("drop_release", ifa.busy, 1'b0);

        // Rotation through all requesters with a 4-beat cap
        ifa.req = 8'hFF;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step();
            chk("rot_gnt", ifa.gnt, 32'(8'b1 << (k % 8)));
            chk("rot_sel", ifa.sel, 32'(k % 8));
            for (int b = 0; b < 4; b++) begin
                chk("rot_beat", ifa.beat_done, 1'b1);
                chk("rot_cnt", dut.beat_cnt_q, 32'(b));
                if (b < 3) step();
            end
            step();
            chk("rot_bubble_busy", ifa.busy, 1'b0);
            chk("rot_bubble_gnt", ifa.gnt, 8'h00);
        end

        // Early drop after two beats
        ifa.req = 8'h04;
        do_reset();
        step();
        chk("drop_gnt", ifa.gnt, 8'h04);
        chk("drop_beat0", ifa.beat_done, 1'b1);
        step();
        chk("drop_beat1", ifa.beat_done, 1'b1);
        step();
        chk("drop_cnt2", dut.beat_cnt_q, 8'd2);
        ifa.req = 8'h09;
        #1;
        chk("drop_no_beat", ifa.beat_done, 1'b0);
        step();
        chk("drop_busy", ifa.busy, 1'b0);
        chk("drop_cnt0", dut.beat_cnt_q, 8'd0);
        step();
        chk("drop_next_gnt", ifa.gnt, 8'h08);
        chk("drop_next_sel", ifa.sel, 3'd3);

        // Backpressure holds the grant with no progress
        ifa.req       = 8'h20;
        ifa.out_ready = 1'b0;
        do_reset();
        step();
        for (int c = 0; c < 10; c++) begin
            chk("bp_gnt", ifa.gnt, 8'h20);
            chk("bp_beat", ifa.beat_done, 1'b0);
            chk("bp_cnt", dut.beat_cnt_q, 8'd0);
            step();
        end
        ifa.out_ready = 1'b1;
        #1;
        for (int b = 0; b < 4; b++) begin
            chk("bp_go_beat", ifa.beat_done, 1'b1);
            chk("bp_go_gnt", ifa.gnt, 8'h20);
            step();
        end
        chk("bp_release", ifa.busy, 1'b0);

        // Wrap-around priority
        ifa.req = 8'h40;
        do_reset();
        step();
        chk("wrap_gnt6", ifa.gnt, 8'h40);
        ifa.req = 8'h00;
        step();
        chk("wrap_idle", ifa.busy, 1'b0);
        ifa.req = 8'h41;
        step();
        chk("wrap_gnt0", ifa.gnt, 8'h01);
        chk("wrap_sel0", ifa.sel, 3'd0);
        ifa.req = 8'h00;
        step();
        ifa.req = 8'h41;
        step();
        chk("wrap_gnt6b", ifa.gnt, 8'h40);
        chk("wrap_sel6", ifa.sel, 3'd6);
        ifa.req = 8'h00;

        // Unlimited burst with counter saturation
        ifb.req = 8'h03;
        do_reset();
        step();
        chk("unl_gnt", ifb.gnt, 8'h01);
        for (int c = 0; c < 300; c++) begin
            if (c == 100 || c == 299) chk("unl_hold", ifb.gnt, 8'h01);
            step();
        end
        chk("unl_cnt_sat", dut_u.beat_cnt_q, 8'd255);
        chk("unl_busy", ifb.busy, 1'b1);
        ifb.req = 8'h02;
        step();
        chk("unl_release", ifb.busy, 1'b0);
        step();
        chk("unl_next_gnt", ifb.gnt, 8'h02);
        chk("unl_next_sel", ifb.sel, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
